// File: rtl/bin_search_ctrl.sv
// bin_search_ctrl
//   Sequencer for a binary search over an ascending, unsigned synchronous RAM.
//   Latches the target on start, then probes the RAM at the lo/hi midpoint. Each
//   probe waits RD_LAT cycles for the read data, then narrows the lo/hi window or
//   finishes. The result is held under a level done handshake.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; abandons any search and returns to idle
//   start    in   level request, sampled only while idle or done
//   target   in   search value, latched when a search starts
//   rd_en    out  RAM read strobe, one cycle per probe
//   rd_addr  out  RAM read address (current midpoint)
//   rd_data  in   RAM read data, valid RD_LAT cycles after rd_en
//   busy     out  search in progress
//   done     out  result available; held until start is released
//   found    out  match flag, meaningful while done
//   loc      out  matching address, meaningful while done and found
//   steps    out  compares made in the current or last search
module bin_search_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] loc,
  output logic [ADDR_W:0]   steps
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // WAIT lasts RD_LAT-1 cycles; the counter is loaded with RD_LAT-2 and exits at zero.
  localparam int              WAIT_INIT_I = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
  localparam logic [1:0]      WAIT_INIT   = WAIT_INIT_I[1:0];
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   STEP_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   STEP_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   lo_r, lo_s;
  logic [ADDR_W-1:0]   hi_r, hi_s;
  logic [ADDR_W-1:0]   mid_r, mid_s;
  logic [ADDR_W-1:0]   loc_r, loc_s;
  logic [DATA_W-1:0]   tgt_r, tgt_s;
  logic [ADDR_W:0]     steps_r, steps_s;
  logic                found_r, found_s;
  logic [1:0]          wcnt_r, wcnt_s;
  logic                rd_en_r, busy_r, done_r;

  // Midpoint formed one bit wider so lo+hi cannot overflow before the halving.
  function automatic logic [ADDR_W-1:0] mid_of(input logic [ADDR_W-1:0] lo_v,
                                               input logic [ADDR_W-1:0] hi_v);
    return ADDR_W'(({1'b0, lo_v} + {1'b0, hi_v}) >> 1);
  endfunction

  // Next-state and next-datapath logic for the search loop.
  always_comb begin
    state_s = state_r;
    lo_s    = lo_r;
    hi_s    = hi_r;
    tgt_s   = tgt_r;
    steps_s = steps_r;
    found_s = found_r;
    loc_s   = loc_r;
    wcnt_s  = wcnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          tgt_s   = target;
          lo_s    = ADDR_ZERO;
          hi_s    = ADDR_ONES;
          steps_s = STEP_ZERO;
          found_s = 1'b0;
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (RD_LAT > 1) begin
          wcnt_s  = WAIT_INIT;
          state_s = S_WAIT;
        end else begin
          state_s = S_COMPARE;
        end
      end
      S_WAIT: begin
        if (wcnt_r == 2'd0) begin
          state_s = S_COMPARE;
        end else begin
          wcnt_s = wcnt_r - 2'd1;
        end
      end
      S_COMPARE: begin
        steps_s = steps_r + STEP_ONE;
        if (rd_data == tgt_r) begin
          found_s = 1'b1;
          loc_s   = mid_r;
          state_s = S_DONE;
        end else if (rd_data < tgt_r) begin
          // Window already collapsed at the top: stepping lo past hi would wrap.
          if (mid_r == hi_r) begin
            found_s = 1'b0;
            state_s = S_DONE;
          end else begin
            lo_s    = mid_r + ADDR_ONE;
            state_s = S_ISSUE;
          end
        end else begin
          // Window already collapsed at the bottom: hi=mid-1 would underflow.
          if (mid_r == lo_r) begin
            found_s = 1'b0;
            state_s = S_DONE;
          end else begin
            hi_s    = mid_r - ADDR_ONE;
            state_s = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_s = S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    // The probe address is fixed on entry to ISSUE so rd_addr can be registered.
    if (state_s == S_ISSUE) begin
      mid_s = mid_of(lo_s, hi_s);
    end else begin
      mid_s = mid_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers and registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_r    <= ADDR_ZERO;
      hi_r    <= ADDR_ONES;
      mid_r   <= ADDR_ZERO;
      loc_r   <= ADDR_ZERO;
      tgt_r   <= {DATA_W{1'b0}};
      steps_r <= STEP_ZERO;
      found_r <= 1'b0;
      wcnt_r  <= 2'd0;
      rd_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      mid_r   <= mid_s;
      loc_r   <= loc_s;
      tgt_r   <= tgt_s;
      steps_r <= steps_s;
      found_r <= found_s;
      wcnt_r  <= wcnt_s;
      rd_en_r <= (state_s == S_ISSUE);
      busy_r  <= (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_COMPARE);
      done_r  <= (state_s == S_DONE);
    end
  end

  assign rd_en   = rd_en_r;
  assign rd_addr = mid_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign found   = found_r;
  assign loc     = loc_r;
  assign steps   = steps_r;

endmodule

// File: tb/tb_bin_search_ctrl.sv
// Bench for bin_search_ctrl: one instance with RD_LAT=1 and one with RD_LAT=2,
// each fed by its own synchronous RAM model over a shared memory array.
module tb_bin_search_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] target;
  logic       sel;   // 0: RD_LAT=1 instance, 1: RD_LAT=2 instance

  always #5 clk = ~clk;

  logic [7:0] mem [32];

  logic       rd_en1, busy1, done1, found1;
  logic [4:0] rd_addr1, loc1;
  logic [5:0] steps1;
  logic [7:0] rd_data1 = 8'd0;
  logic       rd_en2, busy2, done2, found2;
  logic [4:0] rd_addr2, loc2;
  logic [5:0] steps2;
  logic [7:0] rd_data2 = 8'd0;
  logic [7:0] stage2 = 8'd0;
  logic       start1, start2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  bin_search_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .target(target),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .found(found1), .loc(loc1), .steps(steps1));

  bin_search_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .target(target),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .busy(busy2), .done(done2), .found(found2), .loc(loc2), .steps(steps2));

  // RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem[rd_addr1];
  end

  // RAM with two cycles of read latency.
  always @(posedge clk) begin
    if (rd_en2) stage2 <= mem[rd_addr2];
    rd_data2 <= stage2;
  end

  logic       o_rd_en, o_busy, o_done, o_found;
  logic [4:0] o_rd_addr, o_loc;
  logic [5:0] o_steps;
  assign o_rd_en   = sel ? rd_en2   : rd_en1;
  assign o_busy    = sel ? busy2    : busy1;
  assign o_done    = sel ? done2    : done1;
  assign o_found   = sel ? found2   : found1;
  assign o_rd_addr = sel ? rd_addr2 : rd_addr1;
  assign o_loc     = sel ? loc2     : loc1;
  assign o_steps   = sel ? steps2   : steps1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference results
  bit exp_found;
  int exp_loc, exp_steps;
  int exp_probes[$];

  // Observations from one search
  int obs_probes[$];
  int obs_en_edges[$];
  int obs_done_edge;
  bit obs_timeout;
  int bad_en;
  bit res_found, res_busy;
  int res_loc, res_steps;
  bit idle_done, idle_found;
  int idle_steps;

  // Straight binary search over mem using integer lo/hi bounds.
  task automatic model(input logic [7:0] t);
    int lo, hi, mid;
    bit fin;
    lo = 0; hi = 31; fin = 1'b0;
    exp_probes.delete();
    exp_steps = 0; exp_found = 1'b0; exp_loc = 0;
    while (!fin && exp_steps < 64) begin
      mid = (lo + hi) / 2;
      exp_probes.push_back(mid);
      exp_steps++;
      if (mem[mid] == t) begin
        exp_found = 1'b1; exp_loc = mid; fin = 1'b1;
      end else if (mem[mid] < t) begin
        if (mid == hi) fin = 1'b1; else lo = mid + 1;
      end else begin
        if (mid == lo) fin = 1'b1; else hi = mid - 1;
      end
    end
  endtask

  // Start one search on the selected instance and record its behaviour.
  task automatic run_search(input logic [7:0] t, input bit hold);
    obs_probes.delete();
    obs_en_edges.delete();
    obs_done_edge = -1;
    obs_timeout = 1'b0;
    bad_en = 0;
    @(negedge clk);
    target = t;
    start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    target = ~t;   // must be ignored while busy
    if (o_rd_en) begin obs_probes.push_back(int'(o_rd_addr)); obs_en_edges.push_back(0); end
    if (o_rd_en && !o_busy) bad_en++;
    for (int e = 1; e <= 200 && obs_done_edge < 0; e++) begin
      @(posedge clk); #1;
      if (o_rd_en) begin obs_probes.push_back(int'(o_rd_addr)); obs_en_edges.push_back(e); end
      if (o_rd_en && !o_busy) bad_en++;
      if (o_done) obs_done_edge = e;
    end
    if (obs_done_edge < 0) obs_timeout = 1'b1;
    res_found = o_found; res_loc = int'(o_loc); res_steps = int'(o_steps); res_busy = o_busy;
    if (!hold) begin
      @(posedge clk); #1;
      idle_done = o_done; idle_found = o_found; idle_steps = int'(o_steps);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_tests++;
      if ({o_rd_en, o_busy, o_done, o_found, o_rd_addr, o_loc, o_steps} !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d got en=%b busy=%b done=%b found=%b addr=%0d loc=%0d steps=%0d, want all 0",
                 s, o_rd_en, o_busy, o_done, o_found, o_rd_addr, o_loc, o_steps);
      end
    end
  endtask

  task automatic test_lat1_directed();
    logic [7:0] tlist [5];
    tlist[0] = 8'd20; tlist[1] = 8'd0; tlist[2] = 8'd62; tlist[3] = 8'd21; tlist[4] = 8'd63;
    sel = 1'b0;
    for (int k = 0; k < 5; k++) begin
      model(tlist[k]);
      run_search(tlist[k], 1'b0);
      n_tests++;
      if (obs_timeout) begin n_fail++; $display("FAIL lat1_timeout t=%0d no done within 200 edges", tlist[k]); end
      n_tests++;
      if (obs_probes != exp_probes) begin
        n_fail++; $display("FAIL lat1_probes t=%0d got %p want %p", tlist[k], obs_probes, exp_probes);
      end
      n_tests++;
      if (res_found !== exp_found || (exp_found && res_loc != exp_loc)) begin
        n_fail++; $display("FAIL lat1_result t=%0d got found=%b loc=%0d want found=%b loc=%0d",
                           tlist[k], res_found, res_loc, exp_found, exp_loc);
      end
      n_tests++;
      if (res_steps != exp_steps || obs_done_edge != 2 * exp_steps) begin
        n_fail++; $display("FAIL lat1_timing t=%0d got steps=%0d done_edge=%0d want steps=%0d done_edge=%0d",
                           tlist[k], res_steps, obs_done_edge, exp_steps, 2 * exp_steps);
      end
      n_tests++;
      if (bad_en != 0 || res_busy !== 1'b0) begin
        n_fail++; $display("FAIL lat1_strobe t=%0d got stray_rd_en=%0d busy_at_done=%b want 0 0", tlist[k], bad_en, res_busy);
      end
      n_tests++;
      if (idle_done !== 1'b0 || idle_found !== exp_found || idle_steps != exp_steps) begin
        n_fail++; $display("FAIL lat1_idle_hold t=%0d got done=%b found=%b steps=%0d want 0 %b %0d",
                           tlist[k], idle_done, idle_found, idle_steps, exp_found, exp_steps);
      end
    end
  endtask

  task automatic test_lat2();
    bit spacing_ok;
    sel = 1'b1;
    model(8'd20);
    run_search(8'd20, 1'b0);
    n_tests++;
    if (obs_probes != exp_probes || res_found !== 1'b1 || res_loc != 10) begin
      n_fail++; $display("FAIL lat2_result got probes=%p found=%b loc=%0d want %p 1 10", obs_probes, res_found, res_loc, exp_probes);
    end
    n_tests++;
    if (obs_done_edge != 15) begin
      n_fail++; $display("FAIL lat2_done_edge got %0d want 15", obs_done_edge);
    end
    spacing_ok = (obs_en_edges.size() == 5);
    for (int i = 1; i < obs_en_edges.size(); i++)
      if (obs_en_edges[i] - obs_en_edges[i-1] != 3) spacing_ok = 1'b0;
    n_tests++;
    if (!spacing_ok) begin
      n_fail++; $display("FAIL lat2_spacing got rd_en edges %p want 5 pulses 3 apart", obs_en_edges);
    end
  endtask

  task automatic test_hold_start();
    sel = 1'b0;
    model(8'd30);
    run_search(8'd30, 1'b1);
    n_tests++;
    if (obs_timeout || res_found !== 1'b1 || res_loc != 15) begin
      n_fail++; $display("FAIL hold_result got timeout=%b found=%b loc=%0d want 0 1 15", obs_timeout, res_found, res_loc);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (o_done !== 1'b1 || o_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL hold_done cycle=%0d got done=%b rd_en=%b want 1 0", c, o_done, o_rd_en);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got done=%b busy=%b want 0 0", o_done, o_busy);
    end
    run_search(8'd40, 1'b0);
    n_tests++;
    if (res_found !== 1'b1 || res_loc != 20) begin
      n_fail++; $display("FAIL hold_restart got found=%b loc=%0d want 1 20", res_found, res_loc);
    end
  endtask

  task automatic test_reset_mid();
    int nedge [2];
    nedge[0] = 4;   // RD_LAT=1: third probe's ISSUE, rd_en high
    nedge[1] = 7;   // RD_LAT=2: third probe's WAIT
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      target = 8'd20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (nedge[s]) @(posedge clk);
      #1;
      n_tests++;
      if (o_busy !== 1'b1 || o_steps != 6'd2 || o_rd_en !== (s == 0)) begin
        n_fail++; $display("FAIL midreset_pre sel=%0d got busy=%b steps=%0d rd_en=%b want 1 2 %b", s, o_busy, o_steps, o_rd_en, s == 0);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if ({o_rd_en, o_busy, o_done, o_found, o_rd_addr, o_loc, o_steps} !== 19'd0) begin
        n_fail++;
        $display("FAIL midreset_state sel=%0d got en=%b busy=%b done=%b found=%b addr=%0d loc=%0d steps=%0d, want all 0",
                 s, o_rd_en, o_busy, o_done, o_found, o_rd_addr, o_loc, o_steps);
      end
      @(negedge clk);
      reset = 1'b0;
      model(8'd20);
      run_search(8'd20, 1'b0);
      n_tests++;
      if (obs_timeout || obs_probes != exp_probes || res_found !== 1'b1 || res_loc != 10) begin
        n_fail++; $display("FAIL midreset_clean sel=%0d got probes=%p found=%b loc=%0d want %p 1 10", s, obs_probes, res_found, res_loc, exp_probes);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] t;
    int v, lat;
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0) begin
        v = $urandom_range(0, 5);
        for (int i = 0; i < 32; i++) begin mem[i] = v[7:0]; v = v + $urandom_range(0, 7); end
      end
      sel = $urandom_range(0, 1);
      lat = sel ? 2 : 1;
      if ($urandom_range(0, 1) == 1) t = mem[$urandom_range(0, 31)];
      else t = 8'($urandom_range(0, 255));
      model(t);
      run_search(t, 1'b0);
      n_tests++;
      if (obs_timeout || obs_probes != exp_probes || res_found !== exp_found || (exp_found && res_loc != exp_loc)
          || res_steps != exp_steps || obs_done_edge != (1 + lat) * exp_steps) begin
        n_fail++;
        $display("FAIL random k=%0d lat=%0d t=%0d got probes=%p found=%b loc=%0d steps=%0d edge=%0d want %p %b %0d %0d %0d",
                 k, lat, t, obs_probes, res_found, res_loc, res_steps, obs_done_edge,
                 exp_probes, exp_found, exp_loc, exp_steps, (1 + lat) * exp_steps);
      end
    end
  endtask

  task automatic test_unsorted();
    logic [7:0] t;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
      sel = k[0];
      t = 8'($urandom_range(0, 255));
      run_search(t, 1'b0);
      n_tests++;
      if (obs_timeout || res_steps > 6 || obs_probes.size() != res_steps) begin
        n_fail++; $display("FAIL unsorted k=%0d got timeout=%b steps=%0d probes=%0d want 0, <=6, equal",
                           k, obs_timeout, res_steps, obs_probes.size());
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; target = 8'd0; sel = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i);
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_lat1_directed();
    test_lat2();
    test_hold_start();
    test_reset_mid();
    test_random();
    test_unsorted();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
